rr_arb_mux: RTL and testbench
=============================

Name: rr_arb_mux

Overview:
- Parametrised successor to the fixed 3-input datapath select.
- N_CH input channels, each with a valid/ready handshake. A round-robin arbiter chooses one valid channel per cycle and loads its data into a single registered output stage with valid/ready.
- Used wherever several pipeline producers share one consumer, e.g. writeback or forwarding sources competing for one bus.

Parameters:
- DATA_W, 32, width of each channel's data.
- N_CH, 3, number of input channels (legal range 1..16).
- SEL_W, derived localparam = max(1, clog2(N_CH)), width of grant index.

Ports:
- clk_i, input, 1, clock; all state updates on rising edge.
- rst_i, input, 1, asynchronous active-high reset.
- data_i, input, N_CH*DATA_W, flattened channel data; channel k at bits [k*DATA_W +: DATA_W].
- valid_i, input, N_CH, per-channel request.
- ready_o, output, N_CH, per-channel accept. A transfer occurs on channel k when valid_i[k] && ready_o[k].
- data_o, output, DATA_W, registered output data.
- valid_o, output, 1, output register holds a word.
- ready_i, input, 1, consumer accept.
- grant_o, output, SEL_W, channel index that sourced the current data_o.

Behaviour:
- Reset (async, immediate) values:
  - data_o = 0, valid_o = 0, grant_o = 0.
  - Round-robin pointer last_ptr = N_CH-1, so channel 0 has first priority.
- load = !valid_o || ready_i. This is a combinational path from ready_i to ready_o; full throughput, no bubble.
- Arbitration (combinational, every cycle):
  - Search channels starting at (last_ptr+1) mod N_CH, wrapping upward.
  - The first k with valid_i[k] is the winner.
- ready_o[k] = load && winner_found && (winner == k). At most one bit of ready_o is high.
- On a clock edge with load && winner_found:
  - data_o <= channel winner data, valid_o <= 1, grant_o <= winner, last_ptr <= winner.
- On a clock edge with load && !winner_found:
  - valid_o <= 0; data_o, grant_o and last_ptr hold.
- When !load (valid_o && !ready_i):
  - All outputs and last_ptr hold. data_o must be stable while stalled.
- Latency is 1 cycle from an accepted input to valid_o.
- Sustained rate is 1 word/cycle when ready_i is held high.
- Fairness: with all channels continuously valid, grants cycle 0,1,...,N_CH-1,0,... Any continuously valid channel is served within N_CH accepted transfers.
- Wrap-around: when last_ptr = N_CH-1 the search starts at 0. Pointer arithmetic is modulo N_CH, not 2^SEL_W; non-power-of-two N_CH must never produce an index >= N_CH.
- N_CH = 1: arbiter degenerates to pass-through; grant_o is constant 0.
- Simultaneous ready_i and a new winner in the same cycle: the old word leaves and the new word loads on the same edge.
- Reset asserted mid-transfer: in-flight word is dropped and valid_o falls immediately. No ready_o is asserted while rst_i is high.
- Inputs: valid_i may drop without a transfer; no persistence is required of producers.

Optional Feature:
- Macro: RR_MUX_PRIO0_EN.
- Defined: channel 0 is a fixed-priority override. If valid_i[0], channel 0 wins regardless of last_ptr, and last_ptr is not updated on a channel-0 grant. Remaining channels keep round-robin among themselves.
- Not defined: pure round-robin as above, with channel 0 treated like the others.

Decomposition:
- Shared package/header: DATA_W default (32), maximum N_CH (16), and a clog2 constant function for SEL_W.
- Sub-module rr_arbiter: valid vector in, pointer register, winner index and found flag out, update enable in. Reused by later multi-port blocks.
- rr_arb_mux instantiates rr_arbiter and holds the output register plus load logic.

Test Plan:
- Reset (N_CH=3, DATA_W=32):
  - rst_i pulse mid-cycle → valid_o, data_o, grant_o, ready_o all 0 asynchronously.
  - First grant after release with valid_i=3'b111 is channel 0.
- Round-robin wrap:
  - valid_i=3'b111, data 0xA0/0xB1/0xC2, ready_i=1 for 6 cycles → grant_o sequence 0,1,2,0,1,2 and data_o 0xA0,0xB1,0xC2,...; one transfer per cycle.
- Backpressure:
  - Channel 1 word 0x1234 loaded, ready_i=0 for 4 cycles → data_o=0x1234, valid_o=1 and ready_o=0 throughout.
  - On ready_i=1, next winner loads on the same edge.
- Sparse and idle:
  - valid_i=3'b100 only → grant 2.
  - Then valid_i=3'b011 → grant 0 (search starts after 2, wraps to 0).
  - Then valid_i=0 with ready_i=1 → valid_o=0 next cycle.
- Non-power-of-two bounds:
  - N_CH=5, all valid for 10 transfers → grants 0..4 twice; grant_o never 5..7.
- RR_MUX_PRIO0_EN defined:
  - valid_i=3'b111 continuously → grant_o constantly 0.
  - Drop valid_i[0] → grants alternate 1,2,1,2.

Source files
------------

// File: rtl/rr_arb_mux_pkg.sv
// Shared constants and width helpers for the round-robin arbitrated mux family.
// Optional feature macro used by this family: RR_MUX_PRIO0_EN (channel 0 fixed priority).
package rr_arb_mux_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int N_CH_MAX   = 16;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Grant index width; a single channel still needs a one-bit index.
    function automatic int sel_w(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: rotating search from the slot after the last winner.
// With RR_MUX_PRIO0_EN defined, channel 0 overrides and never moves the pointer.
module rr_arbiter
    import rr_arb_mux_pkg::*;
#(
    parameter int N_CH  = 3,
    parameter int SEL_W = sel_w(N_CH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_CH-1:0]  valid_i,
    input  logic             update_i,
    output logic [SEL_W-1:0] winner_o,
    output logic             found_o
);

    logic [SEL_W-1:0] ptr_r;
    logic [SEL_W-1:0] winner_s;
    logic             found_s;
    logic             upd_s;

    // Winner search; wrap is done modulo N_CH so no index ever reaches N_CH.
    always_comb begin
        int               idx_v;
        logic [SEL_W-1:0] cand_v;
        logic             hit_v;
        idx_v    = 0;
        cand_v   = '0;
        hit_v    = 1'b0;
        winner_s = '0;
        found_s  = 1'b0;
        for (int i = 1; i <= N_CH; i++) begin
            idx_v    = int'(ptr_r) + i;
            idx_v    = (idx_v >= N_CH) ? (idx_v - N_CH) : idx_v;
            cand_v   = SEL_W'(idx_v);
            hit_v    = !found_s && valid_i[cand_v];
            winner_s = hit_v ? cand_v : winner_s;
            found_s  = found_s || hit_v;
        end
`ifdef RR_MUX_PRIO0_EN
        winner_s = valid_i[0] ? '0 : winner_s;
        found_s  = found_s || valid_i[0];
`endif
    end

`ifdef RR_MUX_PRIO0_EN
    assign upd_s = update_i && found_s && (winner_s != '0);
`else
    assign upd_s = update_i && found_s;
`endif

    // Pointer register; reset value makes channel 0 the first candidate.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_r <= SEL_W'(N_CH - 1);
        end else if (upd_s) begin
            ptr_r <= winner_s;
        end
    end

    assign winner_o = winner_s;
    assign found_o  = found_s;

endmodule

// File: rtl/rr_arb_mux.sv
// N_CH-way valid/ready mux with round-robin arbitration and one registered output stage.
// Honours RR_MUX_PRIO0_EN through the rr_arbiter instance.
module rr_arb_mux
    import rr_arb_mux_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int N_CH   = 3,
    localparam int SEL_W  = sel_w(N_CH)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [N_CH*DATA_W-1:0] data_i,
    input  logic [N_CH-1:0]        valid_i,
    output logic [N_CH-1:0]        ready_o,
    output logic [DATA_W-1:0]      data_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [SEL_W-1:0]       grant_o
);

    logic [DATA_W-1:0] data_r;
    logic              valid_r;
    logic [SEL_W-1:0]  grant_r;
    logic              load_s;
    logic [SEL_W-1:0]  winner_s;
    logic              found_s;
    logic [DATA_W-1:0] data_sel_s;
    logic [N_CH-1:0]   ready_s;

    // Output stage can take a word when empty or draining this cycle.
    assign load_s = !valid_r || ready_i;

    rr_arbiter #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_arb (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .valid_i  (valid_i),
        .update_i (load_s),
        .winner_o (winner_s),
        .found_o  (found_s)
    );

    // Per-channel accept and winner data select; no accept while in reset.
    always_comb begin
        ready_s    = '0;
        data_sel_s = '0;
        for (int k = 0; k < N_CH; k++) begin
            ready_s[k] = load_s && found_s && !rst_i && (winner_s == SEL_W'(k));
            data_sel_s = (winner_s == SEL_W'(k)) ? data_i[k*DATA_W +: DATA_W] : data_sel_s;
        end
    end

    // Output register: load winner, drain to empty, or hold while stalled.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_r  <= '0;
            valid_r <= 1'b0;
            grant_r <= '0;
        end else if (load_s) begin
            if (found_s) begin
                data_r  <= data_sel_s;
                valid_r <= 1'b1;
                grant_r <= winner_s;
            end else begin
                valid_r <= 1'b0;
            end
        end
    end

    assign ready_o = ready_s;
    assign data_o  = data_r;
    assign valid_o = valid_r;
    assign grant_o = grant_r;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux: a 3-channel and a 5-channel instance.
// Expectations switch with RR_MUX_PRIO0_EN.
module tb_rr_arb_mux;

`ifdef RR_MUX_PRIO0_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [95:0] data;
    logic [2:0]  valid;
    logic [2:0]  ready_o;
    logic [31:0] data_o;
    logic        valid_o;
    logic        ready_in;
    logic [1:0]  grant;

    logic [159:0] data5;
    logic [4:0]   valid5;
    logic [4:0]   ready5_o;
    logic [31:0]  data5_o;
    logic         valid5_o;
    logic         ready5_in;
    logic [2:0]   grant5;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] ch_word [3];
    int          g;
    logic [31:0] exp_d;

    always #5 clk = ~clk;

    rr_arb_mux #(.DATA_W(32), .N_CH(3)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .data_i  (data),
        .valid_i (valid),
        .ready_o (ready_o),
        .data_o  (data_o),
        .valid_o (valid_o),
        .ready_i (ready_in),
        .grant_o (grant)
    );

    rr_arb_mux #(.DATA_W(32), .N_CH(5)) dut5 (
        .clk_i   (clk),
        .rst_i   (rst),
        .data_i  (data5),
        .valid_i (valid5),
        .ready_o (ready5_o),
        .data_o  (data5_o),
        .valid_o (valid5_o),
        .ready_i (ready5_in),
        .grant_o (grant5)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        ch_word[0] = 32'h0000_00A0;
        ch_word[1] = 32'h0000_00B1;
        ch_word[2] = 32'h0000_00C2;
        rst       = 1'b1;
        data      = {32'h0000_00C2, 32'h0000_00B1, 32'h0000_00A0};
        valid     = 3'b111;
        ready_in  = 1'b1;
        data5     = {32'h54, 32'h53, 32'h52, 32'h51, 32'h50};
        valid5    = 5'b00000;
        ready5_in = 1'b1;

        repeat (2) @(negedge clk);
        check_eq("rst_valid", 32'(valid_o), 32'd0);
        check_eq("rst_data", data_o, 32'd0);
        check_eq("rst_grant", 32'(grant), 32'd0);
        check_eq("rst_ready", 32'(ready_o), 32'd0);

        // Release with all channels requesting: round-robin (or channel-0 lock).
        rst = 1'b0;
        #1;
        for (int i = 0; i < 6; i++) begin
            g = PRIO ? 0 : (i % 3);
            check_eq("wrap_ready", 32'(ready_o), 32'(3'b001 << g));
            @(negedge clk);
            check_eq("wrap_grant", 32'(grant), 32'(g));
            check_eq("wrap_data", data_o, ch_word[g]);
            check_eq("wrap_valid", 32'(valid_o), 32'd1);
        end

`ifdef RR_MUX_PRIO0_EN
        valid = 3'b110;
        for (int i = 0; i < 4; i++) begin
            g = 1 + (i % 2);
            #1;
            check_eq("prio_ready", 32'(ready_o), 32'(3'b001 << g));
            @(negedge clk);
            check_eq("prio_grant", 32'(grant), 32'(g));
            check_eq("prio_data", data_o, ch_word[g]);
        end
`endif

        // Asynchronous reset in the middle of a cycle with a word in flight.
        @(posedge clk);
        #2;
        check_eq("pre_rst_valid", 32'(valid_o), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_valid", 32'(valid_o), 32'd0);
        check_eq("mid_rst_data", data_o, 32'd0);
        check_eq("mid_rst_grant", 32'(grant), 32'd0);
        check_eq("mid_rst_ready", 32'(ready_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Backpressure: hold channel 1 word while consumer stalls.
        ch_word[1] = 32'h0000_1234;
        data = {32'h0000_00C2, 32'h0000_1234, 32'h0000_00A0};
        valid = 3'b010;
        #1;
        check_eq("bp_load_ready", 32'(ready_o), 32'(3'b010));
        @(negedge clk);
        check_eq("bp_load_grant", 32'(grant), 32'd1);
        check_eq("bp_load_data", data_o, 32'h0000_1234);
        ready_in = 1'b0;
        valid    = 3'b111;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq("bp_ready", 32'(ready_o), 32'd0);
            @(negedge clk);
            check_eq("bp_data", data_o, 32'h0000_1234);
            check_eq("bp_valid", 32'(valid_o), 32'd1);
            check_eq("bp_grant", 32'(grant), 32'd1);
        end
        ready_in = 1'b1;
        g = PRIO ? 0 : 2;
        #1;
        check_eq("bp_rel_ready", 32'(ready_o), 32'(3'b001 << g));
        @(negedge clk);
        check_eq("bp_rel_grant", 32'(grant), 32'(g));
        check_eq("bp_rel_data", data_o, ch_word[g]);
        check_eq("bp_rel_valid", 32'(valid_o), 32'd1);

        // Sparse requests and idle drain.
        valid = 3'b100;
        #1;
        check_eq("sp2_ready", 32'(ready_o), 32'(3'b100));
        @(negedge clk);
        check_eq("sp2_grant", 32'(grant), 32'd2);
        check_eq("sp2_data", data_o, 32'h0000_00C2);
        valid = 3'b011;
        #1;
        check_eq("sp0_ready", 32'(ready_o), 32'(3'b001));
        @(negedge clk);
        check_eq("sp0_grant", 32'(grant), 32'd0);
        check_eq("sp0_data", data_o, 32'h0000_00A0);
        valid = 3'b000;
        #1;
        check_eq("idle_ready", 32'(ready_o), 32'd0);
        @(negedge clk);
        check_eq("idle_valid", 32'(valid_o), 32'd0);
        check_eq("idle_grant", 32'(grant), 32'd0);
        check_eq("idle_data", data_o, 32'h0000_00A0);

        // Five channels: wrap must be modulo 5, never 5..7.
        check_eq("n5_idle_valid", 32'(valid5_o), 32'd0);
        valid5 = 5'b11111;
        for (int i = 0; i < 10; i++) begin
            g = PRIO ? 0 : (i % 5);
            exp_d = 32'h50 + 32'(g);
            #1;
            check_eq("n5_ready", 32'(ready5_o), 32'(5'b00001 << g));
            @(negedge clk);
            check_eq("n5_grant", 32'(grant5), 32'(g));
            check_eq("n5_range", 32'(grant5 < 3'd5), 32'd1);
            check_eq("n5_data", data5_o, exp_d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
